// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI initiator and the SPI target.
//               Holds the frame state encoding, default widths and the fixed
//               clock polarity/phase of the link (mode 0).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default frame length in bits and default width of the divider input.
    localparam int SPI_DATA_W_DEF = 8;
    localparam int SPI_DIV_W_DEF  = 8;

    // The link runs in mode 0 only: SCLK idles low, data is sampled on the
    // rising edge and changed on the falling edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Frame sequencing states shared by initiator and target.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // waiting for a frame request
        SETUP = 3'd1,   // cs_n low, first bit on mosi, sclk still low
        HIGH  = 3'd2,   // sclk high phase, miso captured on entry
        LOW   = 3'd3,   // sclk low phase, mosi advanced on entry
        HOLD  = 3'd4,   // cs_n hold time after the last high phase
        DONE  = 3'd5    // one-cycle completion, cs_n released
    } spi_state_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_clk_tick.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_tick
// Description : Loadable down-counter that produces the SCLK half-period
//               timebase. After a load with value div, tick is high once
//               every div+1 clk cycles, the first tick arriving div+1 cycles
//               after the load.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               load  - restart the count and capture div as reload value
//               div   - half-period minus one, in clk cycles
//               tick  - high during the last cycle of each half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_tick
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;

    // The reload value is captured here so a later change of div on the
    // input has no influence on a running frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (load) begin
            r_cnt    <= div;
            r_reload <= div;
        end else if (r_cnt == '0) begin
            r_cnt    <= r_reload;
        end else begin
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // A load restarts the period, so the boundary of the old count is
    // suppressed in that cycle.
    assign tick = (r_cnt == '0) && !load;

endmodule : spi_clk_tick
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI mode-0 initiator, MSB first, single chip select, full
//               duplex fixed-length frames started by a start/busy/done
//               handshake. Each SCLK half-period lasts clk_div+1 clk cycles.
//               Frame: SETUP, then DATA_W HIGH phases separated by LOW
//               phases, then HOLD, all H cycles long, then one DONE cycle.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               start   - frame request, accepted only in IDLE
//               tx_data - frame to transmit, latched on accept
//               clk_div - half-period minus one, latched on accept
//               busy    - high from the cycle after accept until done
//               done    - one-cycle completion pulse
//               rx_data - received frame, updated with done
//               sclk    - SPI clock
//               mosi    - serial data out
//               miso    - serial data in (sampled without synchronizer)
//               cs_n    - active-low chip select
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF,
    parameter int DIV_W  = SPI_DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    // Bit counter must be able to hold the value DATA_W itself.
    localparam int c_BIT_W = $clog2(DATA_W + 1);

    spi_state_e          r_state;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [c_BIT_W-1:0]  r_bit_cnt;

    logic                w_accept;
    logic                w_tick;

    // Requests are only looked at in IDLE; anything arriving in another
    // state is dropped rather than queued.
    assign w_accept = (r_state == IDLE) && start;

    spi_clk_tick #(
        .DIV_W (DIV_W)
    ) u_clk_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .div   (clk_div),
        .tick  (w_tick)
    );

    // Single sequential FSM; every output is a flop updated on the same
    // edge as the state change it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            sclk       <= SPI_CPOL;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
        end else begin
            done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= SETUP;
                        r_tx_shift <= tx_data;
                        r_bit_cnt  <= '0;
                        mosi       <= tx_data[DATA_W-1];
                        sclk       <= SPI_CPOL;
                        cs_n       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                // SETUP and LOW both end with a rising SCLK edge, which is
                // where miso is captured and the bit is counted.
                SETUP, LOW: begin
                    if (w_tick) begin
                        r_state    <= HIGH;
                        sclk       <= ~SPI_CPOL;
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], miso};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                    end
                end

                HIGH: begin
                    if (w_tick) begin
                        sclk <= SPI_CPOL;
                        if (r_bit_cnt == c_BIT_W'(DATA_W)) begin
                            // Last bit already on the wire: keep mosi
                            // stable through the hold time.
                            r_state <= HOLD;
                        end else begin
                            r_state    <= LOW;
                            mosi       <= r_tx_shift[DATA_W-2];
                            r_tx_shift <= r_tx_shift << 1;
                        end
                    end
                end

                HOLD: begin
                    if (w_tick) begin
                        r_state <= DONE;
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= r_rx_shift;
                        mosi    <= 1'b0;
                    end
                end

                // One cycle with cs_n high before IDLE can accept again,
                // giving the minimum two-cycle deselect time.
                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    sclk    <= SPI_CPOL;
                    mosi    <= 1'b0;
                    cs_n    <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : spi_master
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. Stimulus pushes the
//               expected frame into a scoreboard queue; an independent
//               monitor measures the SPI waveform and compares at each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int W  = 8;
    localparam int DW = 8;

    localparam int M_LOOP  = 0;   // miso follows mosi
    localparam int M_RESP  = 1;   // miso from a mode-0 responder word
    localparam int M_ZERO  = 2;   // miso stuck at 0
    localparam int M_ONE   = 3;   // miso stuck at 1

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  tx_data;
    logic [DW-1:0] clk_div;
    logic          busy;
    logic          done;
    logic [W-1:0]  rx_data;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;

    spi_master #(
        .DATA_W (W),
        .DIV_W  (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .clk_div (clk_div),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        int           h;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    int           miso_mode = M_ZERO;
    logic [W-1:0] resp_word = '0;
    int           resp_idx  = 0;
    logic         resp_prev_sclk = 1'b0;
    bit           b2b_phase = 1'b0;
    int           gap_seen  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: what a full-duplex frame returns, from the miso source alone.
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] tx, input int mode, input logic [W-1:0] word);
        case (mode)
            M_LOOP:  return tx;
            M_RESP:  return word;
            M_ZERO:  return '0;
            default: return '1;
        endcase
    endfunction

    // miso sources
    always_comb begin
        miso = 1'b0;
        case (miso_mode)
            M_LOOP:  miso = mosi;
            M_RESP:  miso = (resp_idx < W) ? resp_word[W-1-resp_idx] : 1'b0;
            M_ZERO:  miso = 1'b0;
            default: miso = 1'b1;
        endcase
    end

    // Mode-0 responder: MSB presented when selected, next bit after each
    // falling sclk.
    always @(negedge clk) begin
        if (cs_n)
            resp_idx <= 0;
        else if (resp_prev_sclk && !sclk)
            resp_idx <= resp_idx + 1;
        resp_prev_sclk <= sclk;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int           cs_low, busy_cnt, rises, hi_run, lo_run, phase_err;
        int           mosi_changes, cs_high_run, cur_h;
        logic [W-1:0] mosi_word;
        logic         prev_sclk, prev_cs, prev_mosi;
        bit           gap_armed;
        exp_t         e;

        cs_low = 0; busy_cnt = 0; rises = 0; hi_run = 0; lo_run = 0;
        phase_err = 0; mosi_changes = 0; cs_high_run = 0; mosi_word = '0;
        prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; gap_armed = 1'b0;

        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cs_low = 0; busy_cnt = 0; rises = 0; hi_run = 0; lo_run = 0;
                phase_err = 0; mosi_changes = 0; cs_high_run = 0; mosi_word = '0;
                prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; gap_armed = 1'b0;
                continue;
            end

            cur_h = (exp_q.size() > 0) ? exp_q[0].h : 1;

            if (prev_cs && !cs_n) begin
                if (gap_armed) begin
                    check("b2b_gap", cs_high_run, 2);
                    gap_seen++;
                    gap_armed = 1'b0;
                end
            end

            if (cs_n) begin
                cs_high_run++;
            end else begin
                cs_high_run = 0;
                if (!prev_sclk && sclk) begin
                    if (lo_run != cur_h) phase_err++;
                    lo_run = 0;
                    rises++;
                    mosi_word = {mosi_word[W-2:0], mosi};
                end
                if (prev_sclk && !sclk) begin
                    if (hi_run != cur_h) phase_err++;
                    hi_run = 0;
                end
                if (sclk) hi_run++;
                else      lo_run++;
                cs_low++;
                if (!prev_cs && mosi !== prev_mosi) mosi_changes++;
            end
            if (busy) busy_cnt++;

            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data",     rx_data, e.rx);
                    check("mosi_bits",   mosi_word, e.tx);
                    check("cs_low_len",  cs_low, e.h * (2 * W + 1));
                    check("busy_len",    busy_cnt, e.h * (2 * W + 1));
                    check("sclk_rises",  rises, W);
                    check("sclk_phases", phase_err, 0);
                    check("done_cs_n",   cs_n, 1);
                    check("done_busy",   busy, 0);
                    check("done_mosi",   mosi, 0);
                    if (e.tx == '0 || e.tx == '1)
                        check("mosi_const", mosi_changes, 0);
                    if (b2b_phase) gap_armed = 1'b1;
                end
                cs_low = 0; busy_cnt = 0; rises = 0; hi_run = 0; lo_run = 0;
                phase_err = 0; mosi_changes = 0; mosi_word = '0;
            end

            prev_sclk = sclk;
            prev_cs   = cs_n;
            prev_mosi = mosi;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (!(busy == 1'b0 && done == 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic push_exp(input logic [W-1:0] tx, input logic [DW-1:0] dv, input int mode, input logic [W-1:0] word);
        exp_t e;
        e.tx = tx;
        e.rx = model_rx(tx, mode, word);
        e.h  = int'(dv) + 1;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] tx, input logic [DW-1:0] dv, input int mode,
                        input logic [W-1:0] word, input bit wait_done);
        wait_idle();
        miso_mode = mode;
        resp_word = word;
        tx_data   = tx;
        clk_div   = dv;
        start     = 1'b1;
        push_exp(tx, dv, mode, word);
        @(negedge clk);
        start = 1'b0;
        if (wait_done) wait_drain();
    endtask

    initial begin : stimulus
        int n;
        rst_n   = 1'b0;
        start   = 1'b0;
        tx_data = '0;
        clk_div = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx",   rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback and divided responder frames
        send(8'hA5, 8'd0, M_LOOP, 8'h00, 1'b1);
        send(8'h3C, 8'd3, M_RESP, 8'hC3, 1'b1);

        // Start while busy is dropped; mid-frame input changes are ignored
        send(8'h12, 8'd1, M_LOOP, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        tx_data = 8'hFF;
        clk_div = 8'd7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (60) @(negedge clk);
        check("ignored_start_idle", busy, 0);

        // Constant data with stuck miso
        send(8'h00, 8'd0, M_ONE,  8'h00, 1'b1);
        send(8'hFF, 8'd0, M_ZERO, 8'h00, 1'b1);
        send(8'h00, 8'd2, M_ZERO, 8'h00, 1'b1);
        send(8'hFF, 8'd1, M_ONE,  8'h00, 1'b1);

        // Back-to-back with start held high
        wait_idle();
        b2b_phase = 1'b1;
        miso_mode = M_LOOP;
        clk_div   = 8'd0;
        tx_data   = 8'h01;
        start     = 1'b1;
        push_exp(8'h01, 8'd0, M_LOOP, 8'h00);
        push_exp(8'h80, 8'd0, M_LOOP, 8'h00);
        @(negedge clk);
        tx_data = 8'h80;
        n = 0;
        while (exp_q.size() > 1 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        start = 1'b0;
        wait_drain();
        b2b_phase = 1'b0;
        check("b2b_gap_seen", gap_seen, 1);

        // Reset mid-frame
        send(8'h77, 8'd1, M_LOOP, 8'h00, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rx",   rx_data, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h5A, 8'd0, M_LOOP, 8'h00, 1'b1);

        // Randomized frames
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), DW'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 W'($urandom), 1'b1);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_master
`default_nettype wire
